// File: rtl/salsa_blockmix_ctrl_if.sv
// Block-level handshake bundle for salsa_blockmix_ctrl.
// slave  : the controller side (accepts blocks, presents results).
// master : the ROMix sequencer side (offers blocks, consumes results).
interface salsa_blockmix_ctrl_if;
  logic          in_valid;
  logic          in_ready;
  logic [1023:0] data_in;
  logic          out_valid;
  logic          out_ready;
  logic [1023:0] data_out;

  modport master (
    output in_valid, data_in, out_ready,
    input  in_ready, out_valid, data_out
  );

  modport slave (
    input  in_valid, data_in, out_ready,
    output in_ready, out_valid, data_out
  );
endinterface

// File: rtl/salsa_blockmix_ctrl.sv
// scrypt BlockMix (r=1) sequencer for one feedback-mode salsa datapath.
//   Y0 = salsa(B1 ^ B0), Y1 = salsa(Y0 ^ B1); data_out = {Y1, Y0}.
// ROUNDS double-rounds per salsa pass (4 = salsa20/8, legal 1..15).
// Optional macro SALSA_BLOCKMIX_PERF_EN adds perf_blocks / perf_stall counters.
module salsa_blockmix_ctrl #(
  parameter int unsigned ROUNDS = 4
) (
  input  logic                    clk,
  input  logic                    reset_n,
  salsa_blockmix_ctrl_if.slave    bus,
  output logic                    busy,
  output logic [511:0]            salsa_B,
  output logic [511:0]            salsa_Bx,
  output logic                    salsa_feedback,
  input  logic [511:0]            salsa_Bo
`ifdef SALSA_BLOCKMIX_PERF_EN
  ,
  output logic [31:0]             perf_blocks,
  output logic [31:0]             perf_stall
`endif
);

  typedef enum logic [1:0] {IDLE, MIX0, MIX1, DONE} state_t;

  localparam logic [3:0] RND_LAST = 4'(ROUNDS - 1);

  state_t       state, state_nxt;
  logic [3:0]   rnd, rnd_nxt;
  logic [511:0] b0, b1, y0, y1;
  logic         load_in, load_y0, load_y1;
  logic         rnd_last;

  assign rnd_last = (rnd == RND_LAST);

  // State and round counter register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= IDLE;
      rnd   <= '0;
    end else begin
      state <= state_nxt;
      rnd   <= rnd_nxt;
    end
  end

  // Next-state, round counter and data-capture enables
  always_comb begin
    state_nxt = state;
    rnd_nxt   = rnd;
    load_in   = 1'b0;
    load_y0   = 1'b0;
    load_y1   = 1'b0;
    case (state)
      IDLE: begin
        if (bus.in_valid) begin
          load_in   = 1'b1;
          rnd_nxt   = '0;
          state_nxt = MIX0;
        end
      end
      MIX0: begin
        if (rnd_last) begin
          load_y0   = 1'b1;
          rnd_nxt   = '0;
          state_nxt = MIX1;
        end else begin
          rnd_nxt = rnd + 4'd1;
        end
      end
      MIX1: begin
        if (rnd_last) begin
          load_y1   = 1'b1;
          rnd_nxt   = '0;
          state_nxt = DONE;
        end else begin
          rnd_nxt = rnd + 4'd1;
        end
      end
      DONE: begin
        if (bus.out_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Block capture and per-phase result capture from the datapath
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      b0 <= '0;
      b1 <= '0;
      y0 <= '0;
      y1 <= '0;
    end else begin
      if (load_in) begin
        b0 <= bus.data_in[511:0];
        b1 <= bus.data_in[1023:512];
      end
      if (load_y0) y0 <= salsa_Bo;
      if (load_y1) y1 <= salsa_Bo;
    end
  end

  // Datapath inputs stay on their MIX1 sources outside MIX0 so that B/Bx
  // only change at phase boundaries; the datapath is idle in IDLE/DONE.
  assign salsa_B        = (state == MIX0) ? b0 : y0;
  assign salsa_Bx       = b1;
  assign busy           = (state == MIX0) || (state == MIX1);
  assign salsa_feedback = busy && (rnd != 4'd0);

  assign bus.in_ready   = (state == IDLE);
  assign bus.out_valid  = (state == DONE);
  assign bus.data_out   = {y1, y0};

`ifdef SALSA_BLOCKMIX_PERF_EN
  // Completed-handshake counter (wraps) and DONE backpressure counter (saturates)
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      perf_blocks <= '0;
      perf_stall  <= '0;
    end else begin
      if (state == DONE && bus.out_ready) perf_blocks <= perf_blocks + 32'd1;
      if (state == DONE && !bus.out_ready && perf_stall != '1)
        perf_stall <= perf_stall + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_salsa_blockmix_ctrl.sv
// Scoreboard bench for salsa_blockmix_ctrl with a behavioural feedback-mode
// salsa datapath attached to each instance (ROUNDS=4 and ROUNDS=1).
module tb_salsa_blockmix_ctrl;

  localparam logic [3:0] QR [32] = '{
    4'd0, 4'd4, 4'd8, 4'd12,   4'd5, 4'd9, 4'd13, 4'd1,
    4'd10, 4'd14, 4'd2, 4'd6,  4'd15, 4'd3, 4'd7, 4'd11,
    4'd0, 4'd1, 4'd2, 4'd3,    4'd5, 4'd6, 4'd7, 4'd4,
    4'd10, 4'd11, 4'd8, 4'd9,  4'd15, 4'd12, 4'd13, 4'd14};

  function automatic logic [31:0] rotl(input logic [31:0] v, input int unsigned s);
    return (v << s) | (v >> (32 - s));
  endfunction

  function automatic logic [511:0] dround(input logic [511:0] v);
    logic [31:0]  x [16];
    logic [511:0] r;
    int unsigned  a, b, c, d;
    for (int i = 0; i < 16; i++) x[i] = v[32*i +: 32];
    for (int g = 0; g < 8; g++) begin
      a = QR[4*g]; b = QR[4*g+1]; c = QR[4*g+2]; d = QR[4*g+3];
      x[b] = x[b] ^ rotl(x[a] + x[d], 7);
      x[c] = x[c] ^ rotl(x[b] + x[a], 9);
      x[d] = x[d] ^ rotl(x[c] + x[b], 13);
      x[a] = x[a] ^ rotl(x[d] + x[c], 18);
    end
    for (int i = 0; i < 16; i++) r[32*i +: 32] = x[i];
    return r;
  endfunction

  function automatic logic [511:0] add16(input logic [511:0] p, input logic [511:0] q);
    logic [511:0] r;
    for (int i = 0; i < 16; i++) r[32*i +: 32] = p[32*i +: 32] + q[32*i +: 32];
    return r;
  endfunction

  function automatic logic [511:0] salsa_ref(input logic [511:0] x, input int unsigned n);
    logic [511:0] z;
    z = x;
    for (int i = 0; i < int'(n); i++) z = dround(z);
    return add16(x, z);
  endfunction

  function automatic logic [1023:0] blockmix_ref(input logic [1023:0] d, input int unsigned n);
    logic [511:0] y0, y1;
    y0 = salsa_ref(d[511:0] ^ d[1023:512], n);
    y1 = salsa_ref(y0 ^ d[1023:512], n);
    return {y1, y0};
  endfunction

  function automatic logic [1023:0] rand1024();
    logic [1023:0] r;
    for (int i = 0; i < 32; i++) r[32*i +: 32] = $urandom();
    return r;
  endfunction

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  salsa_blockmix_ctrl_if if4();
  salsa_blockmix_ctrl_if if1();

  logic         busy4, fb4, busy1, fb1;
  logic [511:0] sB4, sBx4, sBo4, xr4, xx4, dr4;
  logic [511:0] sB1, sBx1, sBo1, xr1, xx1, dr1;
`ifdef SALSA_BLOCKMIX_PERF_EN
  logic [31:0]  pblk4, pstall4, pblk1, pstall1;
`endif

  salsa_blockmix_ctrl #(.ROUNDS(4)) dut4 (
    .clk(clk), .reset_n(rst_n), .bus(if4), .busy(busy4),
    .salsa_B(sB4), .salsa_Bx(sBx4), .salsa_feedback(fb4), .salsa_Bo(sBo4)
`ifdef SALSA_BLOCKMIX_PERF_EN
    , .perf_blocks(pblk4), .perf_stall(pstall4)
`endif
  );

  salsa_blockmix_ctrl #(.ROUNDS(1)) dut1 (
    .clk(clk), .reset_n(rst_n), .bus(if1), .busy(busy1),
    .salsa_B(sB1), .salsa_Bx(sBx1), .salsa_feedback(fb1), .salsa_Bo(sBo1)
`ifdef SALSA_BLOCKMIX_PERF_EN
    , .perf_blocks(pblk1), .perf_stall(pstall1)
`endif
  );

  // Behavioural feedback-mode datapath: one double round per clock,
  // Bo = xx + doubleround(feedback ? xr : xx).
  assign xx4  = sB4 ^ sBx4;
  assign dr4  = dround(fb4 ? xr4 : xx4);
  assign sBo4 = add16(xx4, dr4);
  always @(posedge clk) xr4 <= dr4;

  assign xx1  = sB1 ^ sBx1;
  assign dr1  = dround(fb1 ? xr1 : xx1);
  assign sBo1 = add16(xx1, dr1);
  always @(posedge clk) xr1 <= dr1;

  int unsigned n_checks = 0;
  int unsigned n_pass   = 0;

  task automatic chkw(input string nm, input logic [1023:0] got, input logic [1023:0] exp);
    int w;
    n_checks++;
    if (got === exp) n_pass++;
    else begin
      w = 0;
      for (int i = 31; i >= 0; i--) if (got[32*i +: 32] !== exp[32*i +: 32]) w = i;
      $display("FAIL %s: word %0d got %h expected %h", nm, w, got[32*w +: 32], exp[32*w +: 32]);
    end
  endtask

  task automatic chk32(input string nm, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", nm, got, exp);
  endtask

  task automatic chk1(input string nm, input logic got, input logic exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %b expected %b", nm, got, exp);
  endtask

  typedef struct {
    logic [1023:0] d;
    int unsigned   acc;
  } exp_t;
  exp_t sb[$];

  // Monitor: latency on out_valid rise, data compare on each handshake.
  logic ov_q = 1'b0;
  always @(negedge clk) begin
    exp_t e;
    if (!rst_n) ov_q = 1'b0;
    else begin
      if (if4.out_valid && !ov_q) begin
        if (sb.size() == 0) chk1("unexpected_out_valid", 1'b1, 1'b0);
        else chk32("latency", 32'(cyc - sb[0].acc), 32'd8);
        chk1("in_ready_in_done", if4.in_ready, 1'b0);
      end
      if (if4.out_valid && if4.out_ready && sb.size() != 0) begin
        e = sb.pop_front();
        chkw("data_out", if4.data_out, e.d);
      end
      ov_q = if4.out_valid;
    end
  end

  logic fb1_seen = 1'b0;
  always @(negedge clk) if (fb1 === 1'b1) fb1_seen = 1'b1;

  // Offer a block at the current cycle and return #1 after its accept edge.
  task automatic send(input logic [1023:0] d, input bit push, input logic [1023:0] expv);
    int unsigned n;
    exp_t e;
    if4.in_valid = 1'b1;
    if4.data_in  = d;
    n = 0;
    @(negedge clk);
    while (!if4.in_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (!if4.in_ready) begin
      chk1("send_timeout", if4.in_ready, 1'b1);
      if4.in_valid = 1'b0;
      return;
    end
    @(posedge clk);
    #1;
    if4.in_valid = 1'b0;
    if4.data_in  = rand1024();
    if (push) begin
      e.d   = expv;
      e.acc = cyc;
      sb.push_back(e);
    end
  endtask

  task automatic drain();
    int unsigned n;
    n = 0;
    while (sb.size() != 0 && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (sb.size() != 0) chk32("drain_timeout", 32'(sb.size()), 32'd0);
    @(posedge clk);
    #1;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [1023:0] blk, dv;
    logic [511:0]  b0s, b1s, y0e;
    int unsigned   n, a;

    rst_n = 1'b0;
    if4.in_valid = 1'b0; if4.data_in = '0; if4.out_ready = 1'b1;
    if1.in_valid = 1'b0; if1.data_in = '0; if1.out_ready = 1'b1;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    chk1("reset_in_ready",  if4.in_ready,  1'b1);
    chk1("reset_out_valid", if4.out_valid, 1'b0);
    chk1("reset_busy",      busy4,         1'b0);
    chk1("reset_feedback",  fb4,           1'b0);
    chkw("reset_salsa_B",   {512'd0, sB4},  '0);
    chkw("reset_salsa_Bx",  {512'd0, sBx4}, '0);
    chkw("reset_data_out",  if4.data_out,  '0);

    // Zero vector: salsa(0) = 0, so every stage is all-zero.
    @(posedge clk); #1;
    send('0, 1'b1, '0);
    @(negedge clk);
    chk1("zero_in_ready_drop", if4.in_ready, 1'b0);
    repeat (8) @(posedge clk);
    @(negedge clk);
    chk1("zero_out_valid_at_8", if4.out_valid, 1'b1);
    @(posedge clk);
    @(negedge clk);
    chk1("zero_in_ready_back", if4.in_ready, 1'b1);
    drain();

    // Sequencing of B/Bx/feedback through both phases.
    for (int i = 0; i < 64; i++) begin
      b0s[8*i +: 8] = 8'h01;
      b1s[8*i +: 8] = 8'h02;
    end
    blk = {b1s, b0s};
    y0e = salsa_ref(b0s ^ b1s, 4);
    send(blk, 1'b1, blockmix_ref(blk, 4));
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      chk1("seq_feedback", fb4, (k % 4) != 0);
      chkw("seq_salsa_B", {512'd0, sB4}, {512'd0, (k < 4) ? b0s : y0e});
      chkw("seq_salsa_Bx", {512'd0, sBx4}, {512'd0, b1s});
    end
    drain();

    // Backpressure: 5 DONE cycles with out_ready low.
    if4.out_ready = 1'b0;
    blk = rand1024();
    send(blk, 1'b1, blockmix_ref(blk, 4));
    n = 0;
    @(negedge clk);
    while (!if4.out_valid && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk1("bp_out_valid_seen", if4.out_valid, 1'b1);
    dv = if4.data_out;
    for (int i = 0; i < 5; i++) begin
      chk1("bp_out_valid_hold", if4.out_valid, 1'b1);
      chkw("bp_data_hold", if4.data_out, dv);
      chk1("bp_in_ready_low", if4.in_ready, 1'b0);
      @(posedge clk);
    end
    #1;
    if4.out_ready = 1'b1;
`ifdef SALSA_BLOCKMIX_PERF_EN
    @(negedge clk);
    chk32("perf_stall", pstall4, 32'd5);
`endif
    drain();

    // Random blocks, offered back to back.
    for (int i = 0; i < 200; i++) begin
      blk = rand1024();
      send(blk, 1'b1, blockmix_ref(blk, 4));
    end
    drain();

    // Reset asserted during MIX1 with rnd=2.
    blk = rand1024();
    send(blk, 1'b0, '0);
    repeat (6) @(posedge clk);
    #1;
    chk1("midop_busy_before", busy4, 1'b1);
    chk1("midop_fb_before", fb4, 1'b1);
    #1;
    rst_n = 1'b0;
    #1;
    chk1("midop_out_valid", if4.out_valid, 1'b0);
    chk1("midop_busy", busy4, 1'b0);
    chk1("midop_feedback", fb4, 1'b0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk1("midop_in_ready", if4.in_ready, 1'b1);
    chkw("midop_data_out", if4.data_out, '0);
    @(posedge clk); #1;
    blk = rand1024();
    send(blk, 1'b1, blockmix_ref(blk, 4));
    drain();

    // ROUNDS=1 instance.
    blk = rand1024();
    if1.in_valid = 1'b1;
    if1.data_in  = blk;
    @(negedge clk);
    chk1("r1_in_ready", if1.in_ready, 1'b1);
    @(posedge clk);
    #1;
    a = cyc;
    if1.in_valid = 1'b0;
    n = 0;
    @(negedge clk);
    while (!if1.out_valid && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk32("r1_latency", 32'(cyc - a), 32'd2);
    chkw("r1_data_out", if1.data_out, blockmix_ref(blk, 1));
    chk1("r1_feedback_never", fb1_seen, 1'b0);
    repeat (2) @(negedge clk);

    chk32("scoreboard_empty", 32'(sb.size()), 32'd0);
`ifdef SALSA_BLOCKMIX_PERF_EN
    chk32("perf_blocks", pblk4, 32'd1);
`endif

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
